// File: rtl/dsp_mem_arbiter_pkg.sv
// rtl/dsp_mem_arbiter_pkg.sv - shared widths and arbiter state encoding
// Purpose: word/address widths reused across the DSP memory slice and the
//          two-state arbiter encoding (ARB_CORE / ARB_DMA).
// Ports:   none (package).
package dsp_mem_arbiter_pkg;

  localparam int REG_WORD_LEN  = 16;
  localparam int SRAM_ADDR_LEN = 10;
  localparam int ARB_STATE_LEN = 1;

  typedef enum logic [ARB_STATE_LEN-1:0] {
    ARB_CORE = 1'b0,
    ARB_DMA  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dsp_mem_arbiter_if.sv
// rtl/dsp_mem_arbiter_if.sv - core memory-stage and DMA sample stream bundle
// Purpose: groups the core LD/ST request signals and the DMA sample handshake.
// Ports:   core_req/core_we/core_addr/core_wdata -> arbiter, core_rdata/core_stall <- arbiter,
//          dma_valid/dma_data -> arbiter, dma_ready <- arbiter.
//          master = core/DMA side, slave = arbiter side.
interface dsp_mem_arbiter_if
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_WORD_LEN
);

  logic              core_req;
  logic              core_we;
  logic [DATA_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              dma_valid;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_data;

  modport master (
    output core_req, core_we, core_addr, core_wdata, dma_valid, dma_data,
    input  core_rdata, core_stall, dma_ready
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, dma_valid, dma_data,
    output core_rdata, core_stall, dma_ready
  );

endinterface

// File: rtl/dsp_mem_arbiter_ring_addr_gen.sv
// rtl/dsp_mem_arbiter_ring_addr_gen.sv - ring buffer write pointer and address
// Purpose: holds the ring write pointer, advances it on each write strobe with
//          wrap at len-1, forms base+ptr (carry dropped) and pulses wrap one
//          cycle after the wrapping write.
// Ports:   clk, rst_n, clr (sync pointer clear), wr_stb, base, len -> in;
//          wr_addr, wrap -> out.
module dsp_ring_addr_gen
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_stb,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wrap
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wrap_q, wrap_d;
  logic              at_end;

  assign at_end  = (wr_ptr_q == len - ADDR_W'(1));
  assign wr_addr = base + wr_ptr_q;
  assign wrap    = wrap_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wrap_d   = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
    end else if (wr_stb) begin
      wr_ptr_d = at_end ? '0 : wr_ptr_q + ADDR_W'(1);
      wrap_d   = at_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wrap_q   <= wrap_d;
    end
  end

endmodule

// File: rtl/dsp_mem_arbiter.sv
// rtl/dsp_mem_arbiter.sv - two-bank DSP SRAM arbiter between core LD/ST and sample DMA
// Purpose: core has priority on the ring bank; a buffered DMA sample blocked
//          for MAX_WAIT-1 cycles forces one ARB_DMA cycle that stalls the core
//          only if it targets the ring bank. Samples pass a 1-entry buffer.
// Ports:   clk, rst_n (async active-low); bus (slave modport: core + DMA);
//          ring_bank/ring_base/ring_len/ring_clr config, ring_wrap pulse;
//          b1_*/b2_* SRAM bank ports (combinational read data in).
// Option:  DSP_MEM_ARB_STATS_EN adds stat_stall_cnt / stat_drop_cnt outputs.
module dsp_mem_arbiter
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int DATA_W   = REG_WORD_LEN,
  parameter int ADDR_W   = SRAM_ADDR_LEN,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dsp_mem_arbiter_if.slave  bus,
  input  logic              ring_bank,
  input  logic [ADDR_W-1:0] ring_base,
  input  logic [ADDR_W-1:0] ring_len,
  input  logic              ring_clr,
  output logic              ring_wrap,
`ifdef DSP_MEM_ARB_STATS_EN
  output logic [15:0]       stat_stall_cnt,
  output logic [15:0]       stat_drop_cnt,
`endif
  output logic [ADDR_W-1:0] b1_addr,
  output logic              b1_we,
  output logic [DATA_W-1:0] b1_wdata,
  input  logic [DATA_W-1:0] b1_rdata,
  output logic [ADDR_W-1:0] b2_addr,
  output logic              b2_we,
  output logic [DATA_W-1:0] b2_wdata,
  input  logic [DATA_W-1:0] b2_rdata
);

  localparam int BANK_BIT = DATA_W - 1;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic              buf_vld_q, buf_vld_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              core_to_ring, conflict, dma_accept, dma_we, core_go;
  logic [ADDR_W-1:0] ring_addr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.core_addr[BANK_BIT-1:ADDR_W];

  assign core_to_ring  = bus.core_req & (bus.core_addr[BANK_BIT] == ring_bank);
  assign conflict      = core_to_ring & buf_vld_q;
  assign bus.dma_ready = ~buf_vld_q & (ring_len != '0) & ~ring_clr;
  assign dma_accept    = bus.dma_valid & bus.dma_ready;
  assign wait_inc      = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    buf_vld_d      = buf_vld_q;
    buf_data_d     = buf_data_q;
    bus.core_stall = 1'b0;
    dma_we         = 1'b0;
    case (state_q)
      ARB_CORE: begin
        dma_we = buf_vld_q & ~conflict;
        if (conflict) begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= WAIT_LIM) state_d = ARB_DMA;
        end
      end
      ARB_DMA: begin
        dma_we         = buf_vld_q;
        bus.core_stall = core_to_ring;
        state_d        = ARB_CORE;
      end
      default: state_d = ARB_CORE;
    endcase
    // A clear drops the buffered sample, so it must not reach the SRAM either.
    dma_we = dma_we & ~ring_clr;
    if (dma_we) begin
      buf_vld_d  = 1'b0;
      wait_cnt_d = '0;
    end else if (dma_accept) begin
      buf_vld_d  = 1'b1;
      buf_data_d = bus.dma_data;
    end
    if (ring_clr) begin
      state_d    = ARB_CORE;
      wait_cnt_d = '0;
      buf_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_CORE;
      wait_cnt_q <= '0;
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
    end
  end

  dsp_ring_addr_gen #(.ADDR_W(ADDR_W)) u_ring_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ring_clr),
    .wr_stb  (dma_we),
    .base    (ring_base),
    .len     (ring_len),
    .wr_addr (ring_addr),
    .wrap    (ring_wrap)
  );

  // Core and DMA never land on the same bank in one cycle: a conflict either
  // blocks the DMA (ARB_CORE) or stalls the core (ARB_DMA).
  assign core_go = bus.core_req & ~bus.core_stall & rst_n;

  always_comb begin
    b1_we    = 1'b0;
    b1_addr  = '0;
    b1_wdata = '0;
    b2_we    = 1'b0;
    b2_addr  = '0;
    b2_wdata = '0;
    if (core_go) begin
      if (bus.core_addr[BANK_BIT]) begin
        b2_addr  = bus.core_addr[ADDR_W-1:0];
        b2_we    = bus.core_we;
        b2_wdata = bus.core_we ? bus.core_wdata : '0;
      end else begin
        b1_addr  = bus.core_addr[ADDR_W-1:0];
        b1_we    = bus.core_we;
        b1_wdata = bus.core_we ? bus.core_wdata : '0;
      end
    end
    if (dma_we) begin
      if (ring_bank) begin
        b2_addr  = ring_addr;
        b2_we    = 1'b1;
        b2_wdata = buf_data_q;
      end else begin
        b1_addr  = ring_addr;
        b1_we    = 1'b1;
        b1_wdata = buf_data_q;
      end
    end
  end

  assign bus.core_rdata = bus.core_addr[BANK_BIT] ? b2_rdata : b1_rdata;

`ifdef DSP_MEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (bus.core_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (ring_clr && buf_vld_q && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// tb/tb_dsp_mem_arbiter.sv - self-checking bench for dsp_mem_arbiter
module tb_dsp_mem_arbiter;
  import dsp_mem_arbiter_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int MW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_mem_arbiter_if #(.DATA_W(DW)) bus ();

  logic          ring_bank, ring_clr, ring_wrap;
  logic [AW-1:0] ring_base, ring_len;
  logic [AW-1:0] b1_addr, b2_addr;
  logic          b1_we, b2_we;
  logic [DW-1:0] b1_wdata, b2_wdata, b1_rdata, b2_rdata;
`ifdef DSP_MEM_ARB_STATS_EN
  logic [15:0]   stat_stall_cnt, stat_drop_cnt;
`endif

  dsp_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ring_bank(ring_bank), .ring_base(ring_base), .ring_len(ring_len),
    .ring_clr(ring_clr), .ring_wrap(ring_wrap),
`ifdef DSP_MEM_ARB_STATS_EN
    .stat_stall_cnt(stat_stall_cnt), .stat_drop_cnt(stat_drop_cnt),
`endif
    .b1_addr(b1_addr), .b1_we(b1_we), .b1_wdata(b1_wdata), .b1_rdata(b1_rdata),
    .b2_addr(b2_addr), .b2_we(b2_we), .b2_wdata(b2_wdata), .b2_rdata(b2_rdata)
  );

  // SRAM bank models (combinational read, write on rising edge)
  logic [DW-1:0] sram1 [DEPTH];
  logic [DW-1:0] sram2 [DEPTH];
  bit            init_mem = 1'b1;
  assign b1_rdata = sram1[b1_addr];
  assign b2_rdata = sram2[b2_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) begin
        sram1[i] <= '0;
        sram2[i] <= '0;
      end
    end else begin
      if (b1_we) sram1[b1_addr] <= b1_wdata;
      if (b2_we) sram2[b2_addr] <= b2_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one pending sample, how long it has been blocked, ring position
  bit            m_pend, m_forced, m_wrap;
  logic [DW-1:0] m_data;
  int            m_ptr, m_blocked, m_stalls, m_drops;
  logic [DW-1:0] ref1 [DEPTH];
  logic [DW-1:0] ref2 [DEPTH];

  int acc_cnt, wrap_cnt, stall_seen, we_cnt, ready_seen;
  bit last_stall, last_ready;
  int wr_log [$];

  task automatic model_reset();
    m_pend = 0; m_forced = 0; m_wrap = 0; m_data = '0;
    m_ptr = 0; m_blocked = 0; m_stalls = 0; m_drops = 0;
  endtask

  task automatic step();
    bit            to_ring, stall, rdy, dwr, cgo;
    int            daddr, cb, caddr, last;
    bit            e_we [2];
    logic [AW-1:0] e_addr [2];
    logic [DW-1:0] e_wd [2];
    last    = int'(ring_len) - 1;
    to_ring = bus.core_req && (bus.core_addr[15] == ring_bank);
    stall   = m_forced && to_ring;
    rdy     = !m_pend && (ring_len != 0) && !ring_clr;
    dwr     = m_pend && !ring_clr && (m_forced || !to_ring);
    cgo     = bus.core_req && !stall;
    cb      = int'(bus.core_addr[15]);
    caddr   = int'(bus.core_addr[AW-1:0]);
    daddr   = (int'(ring_base) + m_ptr) % DEPTH;
    for (int b = 0; b < 2; b++) begin
      e_we[b] = 0; e_addr[b] = '0; e_wd[b] = '0;
    end
    if (cgo) begin
      e_addr[cb] = AW'(caddr);
      e_we[cb]   = bus.core_we;
      e_wd[cb]   = bus.core_we ? bus.core_wdata : '0;
    end
    if (dwr) begin
      e_addr[int'(ring_bank)] = AW'(daddr);
      e_we[int'(ring_bank)]   = 1;
      e_wd[int'(ring_bank)]   = m_data;
    end
    #1;
    check("core_stall", bus.core_stall, stall);
    check("dma_ready", bus.dma_ready, rdy);
    check("ring_wrap", ring_wrap, m_wrap);
    check("b1_we", b1_we, e_we[0]);
    check("b1_addr", b1_addr, e_addr[0]);
    check("b1_wdata", b1_wdata, e_wd[0]);
    check("b2_we", b2_we, e_we[1]);
    check("b2_addr", b2_addr, e_addr[1]);
    check("b2_wdata", b2_wdata, e_wd[1]);
    if (cgo && !bus.core_we)
      check("core_rdata", bus.core_rdata, cb ? ref2[caddr] : ref1[caddr]);
`ifdef DSP_MEM_ARB_STATS_EN
    check("stat_stall_cnt", stat_stall_cnt, m_stalls);
    check("stat_drop_cnt", stat_drop_cnt, m_drops);
`endif
    last_stall = bus.core_stall;
    last_ready = bus.dma_ready;
    stall_seen += int'(bus.core_stall);
    ready_seen += int'(bus.dma_ready);
    wrap_cnt   += int'(ring_wrap);
    we_cnt     += int'(b1_we | b2_we);
    if ((ring_bank ? b2_we : b1_we) && !to_ring)
      wr_log.push_back(int'(ring_bank ? b2_addr : b1_addr));
    @(posedge clk);
    if (dwr) begin
      if (ring_bank) ref2[daddr] = m_data; else ref1[daddr] = m_data;
    end
    if (cgo && bus.core_we) begin
      if (cb == 1) ref2[caddr] = bus.core_wdata; else ref1[caddr] = bus.core_wdata;
    end
    m_stalls += int'(stall);
    if (ring_clr) begin
      if (m_pend) m_drops++;
      m_pend = 0; m_ptr = 0; m_blocked = 0; m_forced = 0; m_wrap = 0;
    end else begin
      m_wrap = dwr && (m_ptr == last);
      if (dwr) begin
        m_ptr = (m_ptr == last) ? 0 : m_ptr + 1;
        m_pend = 0; m_blocked = 0; m_forced = 0;
      end else if (m_pend && to_ring) begin
        m_blocked++;
        if (m_blocked >= MW - 1) m_forced = 1;
      end
      if (bus.dma_valid && rdy) begin
        m_pend = 1;
        m_data = bus.dma_data;
        acc_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dma_valid = 0; bus.dma_data = '0; ring_clr = 0;
  endtask

  task automatic configure(input logic bank, input logic [AW-1:0] base, input logic [AW-1:0] len);
    idle_inputs();
    ring_bank = bank; ring_base = base; ring_len = len;
    ring_clr = 1;
    step();
    ring_clr = 0;
    acc_cnt = 0; wrap_cnt = 0; stall_seen = 0; we_cnt = 0; ready_seen = 0;
    wr_log.delete();
  endtask

  initial begin
    int stall_at, ready5, mism;
    for (int i = 0; i < DEPTH; i++) begin
      ref1[i] = '0;
      ref2[i] = '0;
    end
    model_reset();
    idle_inputs();
    ring_bank = 0; ring_base = '0; ring_len = '0;

    // Reset state
    @(negedge clk);
    init_mem = 0;
    check("rst_ring_wrap", ring_wrap, 0);
    check("rst_b1_we", b1_we, 0);
    check("rst_b2_we", b2_we, 0);
    check("rst_core_stall", bus.core_stall, 0);
    check("rst_dma_ready", bus.dma_ready, 0);
    rst_n = 1;

    // 1: no conflict, ring in bank2, core loads from bank1
    configure(1'b1, 10'h100, 10'd4);
    for (int i = 0; i < 10; i++) begin
      bus.core_req = 1; bus.core_we = 0;
      bus.core_addr = {1'b0, 5'($urandom), 10'($urandom)};
      bus.dma_valid = (acc_cnt < 4);
      bus.dma_data = 16'($urandom);
      step();
    end
    check("t1_wrap_cnt", wrap_cnt, 1);
    check("t1_stalls", stall_seen, 0);
    check("t1_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("t1_addr", wr_log[i], 32'h100 + i);

    // 2: starvation with core storing to the ring bank every cycle
    configure(1'b1, 10'h040, 10'd8);
    stall_at = -1; ready5 = 0;
    for (int i = 0; i < 8; i++) begin
      bus.core_req = 1; bus.core_we = 1;
      bus.core_addr = {1'b1, 5'd0, 10'(i)};
      bus.core_wdata = 16'($urandom);
      bus.dma_valid = (i == 0);
      bus.dma_data = 16'hA5C3;
      step();
      if (last_stall && stall_at < 0) stall_at = i;
      if (i == 5) ready5 = int'(last_ready);
    end
    check("t2_stall_at", stall_at, 4);
    check("t2_ready_after", ready5, 1);
    check("t2_stalls", stall_seen, 1);
    check("t2_sample_mem", ref2[10'h040] == 16'hA5C3, 1);

    // 3: address wrap past the top of the bank
    configure(1'b0, 10'h3FE, 10'd4);
    for (int i = 0; i < 12; i++) begin
      bus.dma_valid = (acc_cnt < 5);
      bus.dma_data = 16'($urandom);
      step();
    end
    check("t3_nwrites", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      check("t3_a0", wr_log[0], 32'h3FE);
      check("t3_a1", wr_log[1], 32'h3FF);
      check("t3_a2", wr_log[2], 32'h000);
      check("t3_a3", wr_log[3], 32'h001);
      check("t3_a4", wr_log[4], 32'h3FE);
    end

    // 4: ring_clr with a sample in the buffer
    configure(1'b0, 10'h200, 10'd8);
    for (int i = 0; i < 5; i++) begin
      bus.dma_valid = (acc_cnt < 2);
      bus.dma_data = 16'($urandom);
      step();
    end
    bus.dma_valid = 1; bus.dma_data = 16'hDEAD;
    step();
    bus.dma_valid = 0; ring_clr = 1;
    step();
    ring_clr = 0;
    for (int i = 0; i < 4; i++) begin
      bus.dma_valid = (acc_cnt < 4);
      bus.dma_data = 16'($urandom);
      step();
    end
    check("t4_nwrites", wr_log.size(), 3);
    if (wr_log.size() == 3) check("t4_after_clr", wr_log[2], 32'h200);
`ifdef DSP_MEM_ARB_STATS_EN
    check("t4_drop_cnt", stat_drop_cnt, 1);
`endif

    // 5: ring_len = 0 disables DMA
    configure(1'b1, 10'h010, 10'd0);
    for (int i = 0; i < 20; i++) begin
      bus.dma_valid = 1'($urandom);
      bus.dma_data = 16'($urandom);
      step();
    end
    check("t5_writes", we_cnt, 0);
    check("t5_ready", ready_seen, 0);

    // Randomized phases
    for (int ph = 0; ph < 5; ph++) begin
      configure(1'($urandom), 10'($urandom), (ph == 4) ? 10'd0 : 10'($urandom_range(1, 6)));
      for (int i = 0; i < 250; i++) begin
        bus.core_req = ($urandom_range(0, 99) < 60);
        bus.core_we = 1'($urandom);
        bus.core_addr = {1'($urandom), 5'($urandom), 10'(ring_base + 10'($urandom_range(0, 7)))};
        bus.core_wdata = 16'($urandom);
        bus.dma_valid = ($urandom_range(0, 99) < 60);
        bus.dma_data = 16'($urandom);
        ring_clr = ($urandom_range(0, 49) == 0);
        step();
      end
      ring_clr = 0;
    end

    // 6: asynchronous reset with a sample buffered and a core store pending
    configure(1'b1, 10'h000, 10'd4);
    bus.dma_valid = 1; bus.dma_data = 16'hBEEF;
    step();
    bus.dma_valid = 0;
    bus.core_req = 1; bus.core_we = 1; bus.core_addr = 16'h0005; bus.core_wdata = 16'h1234;
    #2 rst_n = 0;
    #1;
    check("t6_ring_wrap", ring_wrap, 0);
    check("t6_b1_we", b1_we, 0);
    check("t6_b2_we", b2_we, 0);
    check("t6_core_stall", bus.core_stall, 0);
    check("t6_dma_ready", bus.dma_ready, 1);
    @(posedge clk);
    #1;
    check("t6_edge_b1_we", b1_we, 0);
    check("t6_edge_b2_we", b2_we, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    idle_inputs();
    for (int i = 0; i < 40; i++) begin
      bus.core_req = 1'($urandom);
      bus.core_we = 1'($urandom);
      bus.core_addr = {1'($urandom), 15'($urandom)};
      bus.core_wdata = 16'($urandom);
      bus.dma_valid = 1'($urandom);
      bus.dma_data = 16'($urandom);
      step();
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sram1[i] !== ref1[i]) mism++;
      if (sram2[i] !== ref2[i]) mism++;
    end
    check("mem_final", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
